// File: rtl/div_ctrl.sv
// Sequencing controller for an iterative 32-bit radix-2 divider.
// Holds operands for the whole run, returns the quotient or remainder, and reuses a single cached result.
module div_ctrl #(
    parameter int TAG_W    = 5,
    parameter bit CACHE_EN = 1'b1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_x,
    input  logic [31:0]      in_y,
    input  logic             in_signed,
    input  logic             in_mod,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy,
    output logic             div_en,
    output logic             div_signed,
    output logic [31:0]      div_x,
    output logic [31:0]      div_y,
    input  logic [31:0]      div_s,
    input  logic [31:0]      div_r,
    input  logic             div_complete
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state_q, state_d;
    logic [31:0]        x_q, x_d, y_q, y_d;
    logic               sgn_q, sgn_d, mod_q, mod_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [31:0]        quo_q, quo_d, rem_q, rem_d;
    logic [31:0]        cx_q, cx_d, cy_q, cy_d, cquo_q, cquo_d, crem_q, crem_d;
    logic               cs_q, cs_d, cvld_q, cvld_d;

    logic accept, hit, capture;

    assign accept  = in_valid && (state_q == IDLE) && !flush;
    assign hit     = CACHE_EN && cvld_q && (in_x == cx_q) && (in_y == cy_q) && (in_signed == cs_q);
    // A completion racing a flush must not leak into the result or the cache.
    assign capture = (state_q == BUSY) && div_complete && !flush;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = hit ? DONE : BUSY;
            BUSY:    if (div_complete) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    always_comb begin
        in_ready   = (state_q == IDLE) && !flush;
        out_valid  = (state_q == DONE) && !flush;
        busy       = (state_q != IDLE);
        div_en     = (state_q == BUSY) && !flush;
        div_x      = x_q;
        div_y      = y_q;
        div_signed = sgn_q;
        out_data   = mod_q ? rem_q : quo_q;
        out_tag    = tag_q;
    end

    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        sgn_d  = sgn_q;
        mod_d  = mod_q;
        tag_d  = tag_q;
        quo_d  = quo_q;
        rem_d  = rem_q;
        cx_d   = cx_q;
        cy_d   = cy_q;
        cs_d   = cs_q;
        cquo_d = cquo_q;
        crem_d = crem_q;
        cvld_d = cvld_q;
        if (accept) begin
            x_d   = in_x;
            y_d   = in_y;
            sgn_d = in_signed;
            mod_d = in_mod;
            tag_d = in_tag;
            if (hit) begin
                quo_d = cquo_q;
                rem_d = crem_q;
            end
        end
        if (capture) begin
            quo_d  = div_s;
            rem_d  = div_r;
            cx_d   = x_q;
            cy_d   = y_q;
            cs_d   = sgn_q;
            cquo_d = div_s;
            crem_d = div_r;
            cvld_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            x_q    <= '0;
            y_q    <= '0;
            sgn_q  <= 1'b0;
            mod_q  <= 1'b0;
            tag_q  <= '0;
            quo_q  <= '0;
            rem_q  <= '0;
            cx_q   <= '0;
            cy_q   <= '0;
            cs_q   <= 1'b0;
            cquo_q <= '0;
            crem_q <= '0;
            cvld_q <= 1'b0;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            sgn_q  <= sgn_d;
            mod_q  <= mod_d;
            tag_q  <= tag_d;
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            cx_q   <= cx_d;
            cy_q   <= cy_d;
            cs_q   <= cs_d;
            cquo_q <= cquo_d;
            crem_q <= crem_d;
            cvld_q <= cvld_d;
        end
    end

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl with a behavioural 34-cycle divider attached to the div_* side.
module tb_div_ctrl;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_x = '0, in_y = '0;
    logic        in_signed = 1'b0, in_mod = 1'b0;
    logic [4:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [4:0]  out_tag;
    logic        busy, div_en, div_signed;
    logic [31:0] div_x, div_y, div_s, div_r;
    logic        div_complete;

    int nvec = 0;
    int nmis = 0;
    int den_cnt = 0;
    int mcnt;

    always #5 clk = ~clk;

    div_ctrl #(.TAG_W(5), .CACHE_EN(1'b1)) dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
        .in_signed(in_signed), .in_mod(in_mod), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
        .busy(busy), .div_en(div_en), .div_signed(div_signed), .div_x(div_x), .div_y(div_y),
        .div_s(div_s), .div_r(div_r), .div_complete(div_complete)
    );

    // Divider model: restarts whenever div_en drops, pulses complete in the 34th cycle of div_en.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mcnt <= 0;
            div_complete <= 1'b0;
        end else if (!div_en) begin
            mcnt <= 0;
            div_complete <= 1'b0;
        end else begin
            mcnt <= mcnt + 1;
            div_complete <= (mcnt == 32);
        end
    end

    always @(posedge clk) if (div_en) den_cnt <= den_cnt + 1;

    always_comb begin
        div_s = 32'hFFFF_FFFF;
        div_r = div_x;
        if (div_y != 0) begin
            if (div_signed) begin
                div_s = $signed(div_x) / $signed(div_y);
                div_r = $signed(div_x) % $signed(div_y);
            end else begin
                div_s = div_x / div_y;
                div_r = div_x % div_y;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nmis++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] x, input logic [31:0] y, input logic s,
                        input logic m, input logic [4:0] tag);
        @(negedge clk);
        in_x = x; in_y = y; in_signed = s; in_mod = m; in_tag = tag; in_valid = 1'b1;
        #1 chk("in_ready_at_send", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Cycles from the accept edge until out_valid is seen; 60 means the bound expired.
    task automatic wait_out(output int n);
        n = 0;
        while (n < 60) begin
            @(negedge clk);
            n++;
            #1;
            if (out_valid) break;
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic run(input string name, input logic [31:0] x, input logic [31:0] y,
                       input logic s, input logic m, input logic [4:0] tag,
                       input logic [31:0] exp_data, input int exp_lat);
        int d0, n;
        d0 = den_cnt;
        send(x, y, s, m, tag);
        wait_out(n);
        chk({name, "_latency"}, n, exp_lat);
        chk({name, "_data"}, out_data, exp_data);
        chk({name, "_tag"}, {27'd0, out_tag}, {27'd0, tag});
        chk({name, "_div_en_used"}, {31'd0, den_cnt != d0}, {31'd0, exp_lat != 1});
        handshake();
    endtask

    initial begin
        int n, ov;
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_div_en", {31'd0, div_en}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_tag", {27'd0, out_tag}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        #12 resetn = 1'b1;

        run("div100_7", 32'd100, 32'd7, 1'b1, 1'b0, 5'd3, 32'd14, 35);
        run("mod100_7_hit", 32'd100, 32'd7, 1'b1, 1'b1, 5'd4, 32'd2, 1);
        run("divm7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, 5'd5, 32'hFFFF_FFFD, 35);
        run("modm7_2_hit", 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1, 5'd6, 32'hFFFF_FFFF, 1);
        run("sdivm1_2", 32'hFFFF_FFFF, 32'd2, 1'b1, 1'b0, 5'd7, 32'd0, 35);
        run("udiv_ff_2", 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0, 5'd8, 32'h7FFF_FFFF, 35);

        // Flush ten cycles into a divider run.
        send(32'd50, 32'd5, 1'b1, 1'b0, 5'd9);
        repeat (10) @(negedge clk);
        #1 chk("busy_div_en", {31'd0, div_en}, 32'd1);
        flush = 1'b1;
        #1 chk("flush_div_en", {31'd0, div_en}, 32'd0);
        @(posedge clk);
        #1 flush = 1'b0;
        chk("flush_busy", {31'd0, busy}, 32'd0);
        ov = 0;
        repeat (40) begin
            @(negedge clk);
            #1 if (out_valid) ov++;
        end
        chk("flush_no_out_valid", ov, 0);
        run("umod_ff_2_hit", 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b1, 5'd10, 32'd1, 1);
        run("div9_3", 32'd9, 32'd3, 1'b1, 1'b0, 5'd11, 32'd3, 35);

        // Flush in IDLE blocks acceptance.
        @(negedge clk);
        in_valid = 1'b1; flush = 1'b1; in_x = 32'd5; in_y = 32'd1;
        #1 chk("flush_idle_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1 begin in_valid = 1'b0; flush = 1'b0; end
        chk("flush_idle_busy", {31'd0, busy}, 32'd0);

        // Consumer stalls for five cycles.
        send(32'd1000, 32'd33, 1'b0, 1'b1, 5'd21);
        wait_out(n);
        chk("stall_latency", n, 35);
        for (int i = 0; i < 5; i++) begin
            chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_out_data", out_data, 32'd10);
            chk("stall_out_tag", {27'd0, out_tag}, 32'd21);
            @(negedge clk);
            #1;
        end
        handshake();
        @(negedge clk);
        #1 chk("after_hs_in_ready", {31'd0, in_ready}, 32'd1);
        chk("after_hs_busy", {31'd0, busy}, 32'd0);

        // Flush coincident with div_complete.
        send(32'd77, 32'd7, 1'b1, 1'b0, 5'd12);
        n = 0;
        while (n < 60) begin
            @(negedge clk);
            n++;
            #1;
            if (div_complete) break;
        end
        chk("complete_seen", {31'd0, n < 60}, 32'd1);
        flush = 1'b1;
        #1 chk("fc_out_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        #1 chk("fc_after_out_valid", {31'd0, out_valid}, 32'd0);
        chk("fc_after_busy", {31'd0, busy}, 32'd0);
        run("div77_7_miss", 32'd77, 32'd7, 1'b1, 1'b0, 5'd13, 32'd11, 35);

        // Asynchronous reset mid-run invalidates the cache.
        send(32'd200, 32'd9, 1'b0, 1'b0, 5'd14);
        repeat (5) @(negedge clk);
        #3 resetn = 1'b0;
        #1 chk("arst_div_en", {31'd0, div_en}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        run("mod77_7_post_rst", 32'd77, 32'd7, 1'b1, 1'b1, 5'd15, 32'd0, 35);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
